// File: rtl/prog_feeder_pkg.sv
// Shared definitions for the program feeder: word width, opcode constants,
// instruction layout and the feeder FSM state encoding.
package prog_feeder_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_MV   = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    // Instruction word as seen on the processor din bus
    typedef struct packed {
        logic [OP_W-1:0]        op;
        logic [WORD_W-OP_W-1:0] arg;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_IMM   = 3'd3,
        S_WAIT  = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] w);
        instr_t i;
        i = instr_t'(w);
        return i.op;
    endfunction

endpackage

// File: rtl/prog_feeder_mem.sv
// Program memory: DEPTH x WORD_W array, synchronous write, combinational read.
// Ports: clock, wr_en/wr_addr/wr_data (write), rd_addr -> rd_data (read).
// Contents are deliberately not reset.
module prog_mem
    import prog_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/prog_feeder.sv
// Program feeder: holds a small program and feeds it one instruction at a
// time to the multicycle processor, waiting for done between instructions.
// MVI is followed by its immediate word on din in the next cycle; HALT is
// consumed locally and ends execution.
// Optional macro FEEDER_TIMEOUT_EN: adds a wait-for-done timeout that sets
// the sticky err flag and halts.
// Ports:
//   clock, resetn          clock, async active-low reset
//   start                  pulse; begin at address 0 (ignored while busy)
//   wr_en/wr_addr/wr_data  program load port, taken only while not busy
//   done                   processor done
//   din, run               word and instruction-valid strobe to processor
//   pc                     address of current or next instruction
//   busy, halted, err      status (halted and err are sticky)
module prog_feeder
    import prog_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              done,
    output logic [WORD_W-1:0] din,
    output logic              run,
    output logic [AW-1:0]     pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    // Elaboration-time parameter sanity
    if (DEPTH != (32'd1 << AW)) begin : g_bad_depth
        $error("prog_feeder: DEPTH must equal 2**AW");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("prog_feeder: TIMEOUT must be non-zero");
    end

    state_e            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;

    logic [WORD_W-1:0] rd_data;
    logic              mem_we_c;
    logic              last_c;
    logic              tmo_hit_c;

    // Loads are locked out while a program is executing
    assign mem_we_c = wr_en & ~busy_q;

    // Read address follows pc_d so the registered din can capture the word
    // (instruction or MVI immediate) that is current in the next cycle.
    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_we_c),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pc_d),
        .rd_data (rd_data)
    );

    assign last_c = (pc_q == AW'(DEPTH - 1));

`ifdef FEEDER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // Wait-cycle counter: cleared in ISSUE, counts each IMM/WAIT cycle
    always_comb begin
        tmo_d     = tmo_q;
        tmo_hit_c = 1'b0;
        if (state_q == S_ISSUE) begin
            tmo_d = '0;
        end else if ((state_q == S_IMM) || (state_q == S_WAIT)) begin
            tmo_d     = tmo_q + TW'(1);
            tmo_hit_c = (tmo_d == TW'(TIMEOUT));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Next pc; kept apart from the main FSM block because it feeds the
    // memory read address and must not depend on rd_data.
    always_comb begin
        pc_d = pc_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d = '0;
                end
            end
            S_ISSUE: begin
                if (opcode_of(din_q) == OP_MVI) begin
                    pc_d = pc_q + AW'(1);
                end
            end
            S_IMM, S_WAIT: begin
                if (done) begin
                    pc_d = pc_q + AW'(1);
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    // Next state and registered outputs
    always_comb begin
        state_d  = state_q;
        din_d    = '0;
        run_d    = 1'b0;
        busy_d   = busy_q;
        halted_d = halted_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d  = S_FETCH;
                    busy_d   = 1'b1;
                    halted_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_FETCH: begin
                if (opcode_of(rd_data) == OP_HALT) begin
                    state_d  = S_HALT;
                    busy_d   = 1'b0;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    din_d   = rd_data;
                    run_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                // din_q holds the instruction being issued this cycle
                if (opcode_of(din_q) == OP_MVI) begin
                    state_d = S_IMM;
                    din_d   = rd_data;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_IMM, S_WAIT: begin
                if (done) begin
                    if (last_c) begin
                        state_d  = S_HALT;
                        busy_d   = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (tmo_hit_c) begin
                    state_d  = S_HALT;
                    busy_d   = 1'b0;
                    halted_d = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            din_q    <= din_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign din    = din_q;
    assign run    = run_q;
    assign pc     = pc_q;
    assign busy   = busy_q;
    assign halted = halted_q;
    assign err    = err_q;

endmodule

// File: tb/tb_prog_feeder.sv
// Directed bench for prog_feeder with a din scoreboard and a done model.
module tb_prog_feeder;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        done;
    logic [15:0] din;
    logic        run;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int runs     = 0;
    int done_lat = 1;
    int done_cd  = 0;
    bit done_en  = 1'b0;
    logic [15:0] sb_q[$];

    prog_feeder dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .done    (done),
        .din     (din),
        .run     (run),
        .pc      (pc),
        .busy    (busy),
        .halted  (halted),
        .err     (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    // Done model and din scoreboard, both sampled on the falling edge.
    // done is raised done_lat cycles after the run cycle.
    initial begin
        logic [15:0] exp_w;
        done = 1'b0;
        forever begin
            @(negedge clock);
            done = 1'b0;
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0 && done_en) done = 1'b1;
            end
            if (run === 1'b1) begin
                runs++;
                if (sb_q.size() == 0) begin
                    check("run_without_expectation", 32'(run), 32'd0);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("din_on_run", 32'(din), 32'(exp_w));
                end
                done_cd = done_lat;
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_din",    32'(din),    32'd0);
        check("rst_run",    32'(run),    32'd0);
        check("rst_pc",     32'(pc),     32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err",    32'(err),    32'd0);
        resetn = 1'b1;

        // MVI followed by its immediate, done in the cycle after IMM
        write_word(4'd0, 16'h2800);
        write_word(4'd1, 16'h0005);
        write_word(4'd2, 16'hE000);
        done_en  = 1'b1;
        done_lat = 2;
        sb_q.push_back(16'h2800);
        pulse_start();
        check("mvi_fetch_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("mvi_issue_run", 32'(run), 32'd1);
        check("mvi_issue_din", 32'(din), 32'h2800);
        @(negedge clock);
        check("mvi_imm_run", 32'(run), 32'd0);
        check("mvi_imm_din", 32'(din), 32'h0005);
        check("mvi_imm_pc",  32'(pc),  32'd1);
        wait_halt(50, "mvi_halt");
        check("mvi_halt_pc",   32'(pc),   32'd2);
        check("mvi_halt_busy", 32'(busy), 32'd0);
        check("mvi_halt_run",  32'(run),  32'd0);
        check("mvi_halt_err",  32'(err),  32'd0);

        // Plain instruction with a long wait for done
        write_word(4'd0, 16'h1500);
        write_word(4'd1, 16'hE000);
        done_lat = 4;
        sb_q.push_back(16'h1500);
        pulse_start();
        check("wait_halted_cleared", 32'(halted), 32'd0);
        @(negedge clock);
        check("wait_issue_run", 32'(run), 32'd1);
        check("wait_issue_din", 32'(din), 32'h1500);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("wait_run_low", 32'(run), 32'd0);
            check("wait_din_zero", 32'(din), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
        end
        wait_halt(50, "wait_halt");
        check("wait_halt_pc", 32'(pc), 32'd1);

        // Writes while busy are dropped; writes while idle land
        write_word(4'd0, 16'h1500);
        write_word(4'd1, 16'h1500);
        write_word(4'd2, 16'h1500);
        write_word(4'd3, 16'h0ABC);
        write_word(4'd4, 16'hE000);
        done_lat = 1;
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h0ABC);
        pulse_start();
        write_word(4'd3, 16'h1234);
        wait_halt(100, "busywr_halt1");
        check("busywr_pc", 32'(pc), 32'd4);
        check("busywr_sb_drained1", 32'(sb_q.size()), 32'd0);
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h0ABC);
        pulse_start();
        wait_halt(100, "busywr_halt2");
        check("busywr_sb_drained2", 32'(sb_q.size()), 32'd0);
        write_word(4'd3, 16'h1234);
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h1500);
        sb_q.push_back(16'h1234);
        pulse_start();
        wait_halt(100, "idlewr_halt");
        check("idlewr_sb_drained", 32'(sb_q.size()), 32'd0);

        // Full memory without HALT: runs off the end, pc wraps to 0.
        // A second start mid-run must be ignored.
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), 16'h1500);
            sb_q.push_back(16'h1500);
        end
        runs = 0;
        pulse_start();
        repeat (4) @(negedge clock);
        pulse_start();
        wait_halt(200, "full_halt");
        check("full_runs", 32'(runs), 32'd16);
        check("full_pc", 32'(pc), 32'd0);
        check("full_busy", 32'(busy), 32'd0);
        check("full_sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of WAIT aborts execution
        write_word(4'd0, 16'h1500);
        write_word(4'd1, 16'hE000);
        done_en = 1'b0;
        runs = 0;
        sb_q.push_back(16'h1500);
        pulse_start();
        repeat (3) @(negedge clock);
        check("midrst_busy_before", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_din",    32'(din),    32'd0);
        check("midrst_run",    32'(run),    32'd0);
        check("midrst_pc",     32'(pc),     32'd0);
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (10) @(negedge clock);
        check("midrst_runs", 32'(runs), 32'd1);
        check("midrst_busy_after", 32'(busy), 32'd0);
        check("midrst_sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef FEEDER_TIMEOUT_EN
        // done never comes: err and halt exactly 32 cycles after WAIT entry
        sb_q.push_back(16'h1500);
        pulse_start();
        @(negedge clock);
        check("tmo_issue_run", 32'(run), 32'd1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            check("tmo_err_early", 32'(err), 32'd0);
        end
        @(negedge clock);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_halted", 32'(halted), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
`else
        check("noerr_tied", 32'(err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
